oled_spi_tx: RTL and testbench

- Byte-wide SPI transmitter that sits directly downstream of the OLED sequencing controller.
- Consumes the controller's send_en / send_dc / send_data handshake and reports send_busy back to it.
- Serialises each byte MSB-first onto the SSD1306 4-wire SPI pins (SCLK, MOSI, D/C#, CS#) in SPI mode 0.
- One byte per transaction; CS# is deasserted between bytes.

---
 rtl/oled_spi_tx_if.sv | 29 ++
 rtl/oled_spi_tx.sv | 136 +++++++++++++
 tb/tb_oled_spi_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/oled_spi_tx_if.sv
// -----------------------------------------------------------------------------
// oled_spi_tx_if
// Byte-send handshake between the OLED sequencing controller (master) and the
// SPI byte transmitter (slave).
//   send_en   : transfer request, level-sampled by the transmitter
//   send_dc   : 0 = command byte, 1 = display data byte
//   send_data : byte to serialise
//   send_busy : high while a byte (including CS# recovery) is in flight
// -----------------------------------------------------------------------------
interface oled_spi_tx_if;
  logic       send_en;
  logic       send_dc;
  logic [7:0] send_data;
  logic       send_busy;

  modport master (
    output send_en,
    output send_dc,
    output send_data,
    input  send_busy
  );

  modport slave (
    input  send_en,
    input  send_dc,
    input  send_data,
    output send_busy
  );
endinterface

// File: rtl/oled_spi_tx.sv
// -----------------------------------------------------------------------------
// oled_spi_tx
// Byte-wide SPI mode-0 transmitter for an SSD1306 on the 4-wire bus.
// One byte per transaction, MSB first, CS# released between bytes.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   snd       : send handshake (slave side): send_en/send_dc/send_data in,
//               send_busy out
//   oled_sclk : SPI clock, idle low, half-period CLK_DIV clk cycles
//   oled_mosi : serial data, changes on SCLK falling edges
//   oled_dc   : D/C# pin, copy of the send_dc captured at accept
//   oled_cs   : chip select, active low
// Every output comes straight from a flop.
// Transaction: SETUP (N) -> 8 x (SCLK high N, low N) -> GAP (N) = 18N busy.
// -----------------------------------------------------------------------------
module oled_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  oled_spi_tx_if.slave snd,
  output logic         oled_sclk,
  output logic         oled_mosi,
  output logic         oled_dc,
  output logic         oled_cs
);

  localparam int              CW      = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;     // half-period counter, 0..CLK_DIV-1
  logic [2:0]    bit_q;     // current bit slot, 0 = MSB slot
  logic [6:0]    shift_q;   // remaining bits after the one on MOSI
  logic          busy_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          dc_q;
  logic          cs_q;

  logic          half_done;
  assign half_done = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (snd.send_en) begin
            // Bit 7 goes straight to MOSI; the rest wait in the shifter.
            shift_q <= snd.send_data[6:0];
            mosi_q  <= snd.send_data[7];
            dc_q    <= snd.send_dc;
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            state_q <= SETUP;
          end
        end

        SETUP: begin
          if (half_done) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        SHIFT: begin
          if (half_done) begin
            cnt_q <= '0;
            if (sclk_q) begin
              // Falling edge: advance MOSI, except after bit0 which is held
              // through the last low phase.
              sclk_q <= 1'b0;
              if (bit_q != 3'd7) begin
                mosi_q  <= shift_q[6];
                shift_q <= {shift_q[5:0], 1'b0};
              end
            end else if (bit_q == 3'd7) begin
              cs_q    <= 1'b1;
              mosi_q  <= 1'b0;
              bit_q   <= '0;
              state_q <= GAP;
            end else begin
              bit_q  <= bit_q + 3'd1;
              sclk_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        GAP: begin
          // CS# recovery time; busy stays high so the controller waits.
          if (half_done) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign snd.send_busy = busy_q;
  assign oled_sclk     = sclk_q;
  assign oled_mosi     = mosi_q;
  assign oled_dc       = dc_q;
  assign oled_cs       = cs_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_oled_spi_tx
// Two transmitters (CLK_DIV=4 and CLK_DIV=1) share one stimulus stream.
// Each has a cycle-count model that decides which requests are accepted and
// queues the expected {dc, byte}; a monitor decodes the SPI pins per CS# window
// and checks them against the queue.
// -----------------------------------------------------------------------------
module tb_oled_spi_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dc_in;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  int m_vecs = 0;
  int m_bad  = 0;

  task automatic mchk(input string nm, input int act, input int exp);
    m_vecs++;
    if (act != exp) begin
      m_bad++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int N = (g == 0) ? 4 : 1;

    oled_spi_tx_if sif();
    logic sclk, mosi, dco, cs;

    assign sif.send_en   = en;
    assign sif.send_dc   = dc_in;
    assign sif.send_data = data_in;

    oled_spi_tx #(.CLK_DIV(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .snd       (sif),
      .oled_sclk (sclk),
      .oled_mosi (mosi),
      .oled_dc   (dco),
      .oled_cs   (cs)
    );

    int         vecs = 0;
    int         bad  = 0;
    int         left = 0;       // model: busy cycles remaining
    logic [8:0] q[$];           // expected {dc, byte} in order

    task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
        bad++;
        $display("FAIL u%0d %s got %0h expected %0h", g, nm, act, exp);
      end
    endtask

    // Reference model: idle transmitter accepts when send_en is high and is
    // then busy for 18*N cycles, ignoring everything in between.
    initial begin
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          left = 0;
          q.delete();
        end else if (left > 0) begin
          left--;
        end else if (en) begin
          q.push_back({dc_in, data_in});
          left = 18 * N;
        end
      end
    end

    // Monitor: decode each CS#-low window and score it.
    initial begin : mon
      int         cyc, nb;
      bit         act, err;
      logic       ps, pm, dcw;
      logic [7:0] sh;
      logic [8:0] e;
      cyc = 0; nb = 0; act = 0; err = 0; ps = 0; pm = 0; dcw = 0; sh = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          act = 0; ps = 0; pm = 0;
        end else begin
          chk("busy", int'(sif.send_busy), int'(left > 0));
          if (cs) begin
            chk("idle_sclk", int'(sclk), 0);
            chk("idle_mosi", int'(mosi), 0);
            if (act) begin
              act = 0;
              vecs++;
              if (q.size() == 0) begin
                bad++;
                $display("FAIL u%0d unexpected_byte got %0h expected none", g, sh);
              end else begin
                e = q.pop_front();
                chk("byte", int'(sh), int'(e[7:0]));
                chk("dc", int'(dcw), int'(e[8]));
                chk("rising_edges", nb, 8);
                chk("edge_timing_ok", int'(err), 0);
                chk("cs_low_len", cyc + 1, 17 * N);
              end
            end
          end else begin
            if (!act) begin
              act = 1; cyc = 0; nb = 0; err = 0; sh = '0; dcw = dco;
            end else begin
              cyc++;
              // MOSI may only move on an SCLK falling edge.
              if (mosi != pm && !(ps && !sclk)) err = 1;
            end
            if (dco != dcw) err = 1;
            if (sclk && !ps) begin
              if (cyc != N + 2 * N * nb) err = 1;
              sh = {sh[6:0], mosi};
              nb++;
            end
          end
          ps = sclk;
          pm = mosi;
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input logic [7:0] b, input logic d);
    en = 1'b1; data_in = b; dc_in = d;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_busy0(input logic val);
    int t;
    t = 0;
    while (u[0].sif.send_busy !== val && t < 200) begin
      @(negedge clk);
      t++;
    end
    m_vecs++;
    if (t >= 200) begin
      m_bad++;
      $display("FAIL busy_wait got %0h expected %0h", u[0].sif.send_busy, val);
    end
  endtask

  logic [7:0] seq[3];

  initial begin
    rst_n = 1'b0; en = 1'b0; dc_in = 1'b0; data_in = '0;
    seq[0] = 8'hAE; seq[1] = 8'h00; seq[2] = 8'h10;
    idle_cycles(3);
    mchk("rst0_cs",   u[0].cs, 1);   mchk("rst1_cs",   u[1].cs, 1);
    mchk("rst0_sclk", u[0].sclk, 0); mchk("rst1_sclk", u[1].sclk, 0);
    mchk("rst0_mosi", u[0].mosi, 0); mchk("rst1_mosi", u[1].mosi, 0);
    mchk("rst0_dc",   u[0].dco, 0);  mchk("rst1_dc",   u[1].dco, 0);
    mchk("rst0_busy", u[0].sif.send_busy, 0);
    mchk("rst1_busy", u[1].sif.send_busy, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single command byte, then a data byte of all ones.
    send_pulse(8'hA5, 1'b0); idle_cycles(80);
    send_pulse(8'hFF, 1'b1); idle_cycles(80);

    // Request while busy is ignored.
    send_pulse(8'h3C, 1'b0);
    idle_cycles(9);
    send_pulse(8'h00, 1'b1);
    idle_cycles(80);

    // Controller-style handshake.
    for (int i = 0; i < 3; i++) begin
      wait_busy0(1'b0);
      en = 1'b1; data_in = seq[i]; dc_in = 1'b0;
      @(negedge clk);
      wait_busy0(1'b1);
      en = 1'b0;
    end
    idle_cycles(80);

    // send_en held high: back-to-back bytes.
    en = 1'b1; data_in = 8'h81; dc_in = 1'b0;
    idle_cycles(200);
    en = 1'b0;
    idle_cycles(80);

    // Reset mid-byte.
    en = 1'b1; data_in = 8'h5A; dc_in = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    mchk("midrst_cs",   u[0].cs, 1);
    mchk("midrst_sclk", u[0].sclk, 0);
    mchk("midrst_mosi", u[0].mosi, 0);
    mchk("midrst_busy", u[0].sif.send_busy, 0);
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(1);
    send_pulse(8'h12, 1'b1); idle_cycles(80);

    // Random request levels with data/dc changing every cycle.
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) en = ~en;
      data_in = 8'($urandom);
      dc_in   = 1'($urandom);
    end
    en = 1'b0;
    idle_cycles(100);

    mchk("leftover_q0", u[0].q.size(), 0);
    mchk("leftover_q1", u[1].q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             m_vecs + u[0].vecs + u[1].vecs, m_bad + u[0].bad + u[1].bad);
    $finish;
  end

endmodule
